cfb_enc_ctrl: RTL and testbench
===============================

// Module: cfb_enc_ctrl
// PURPOSE
//  Sequencer for streaming AES-128 CFB-128 encryption around one multi-cycle AES core (start/done handshake).
//  Holds the chaining register, runs AES(iv) while the next plaintext arrives, then XORs plaintext with the keystream.
//  Feeds the result back as the next IV and emits ciphertext on a valid/ready stream; counts blocks (65536-block images).
//  Sits between the image block source/sink and the AES core; the key is wired straight to the core, not handled here.
// PARAMETERS
//  DW      128   block width (fixed at 128 for AES; parameterised for bench stubs)
//  CNT_W   17    width of blk_count; wraps modulo 2^CNT_W
//  TMO_W   8     width of the AES timeout counter; timeout = 2^TMO_W-1 cycles in GEN without aes_done
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  cfg_load   in   1      pulse: load cfg_iv, clear blk_count and err, start a new stream
//  cfg_iv     in   DW     initial vector, sampled when cfg_load is accepted
//  pt_data    in   DW     plaintext block
//  pt_valid   in   1      plaintext valid
//  pt_ready   out  1      plaintext accept (high only in KS_RDY)
//  ct_data    out  DW     ciphertext block (registered)
//  ct_valid   out  1      ciphertext valid
//  ct_ready   in   1      sink accept
//  aes_start  out  1      one-cycle start pulse to the AES core
//  aes_in     out  DW     AES input (= iv_q), held stable for the whole GEN state
//  aes_done   in   1      AES core result-valid pulse
//  aes_out    in   DW     AES result, sampled when aes_done=1
//  blk_count  out  CNT_W  ciphertext blocks delivered since the last cfg_load
//  busy       out  1      state != IDLE
//  err        out  1      sticky AES timeout flag
// BEHAVIOUR
//  Reset: state=IDLE; iv_q, ks_q, ct_data=0; ct_valid, aes_start, pt_ready, err=0; blk_count=0.
//  FSM states: IDLE, GEN, KS_RDY, OUT.
//   IDLE:   cfg_load -> iv_q<=cfg_iv, blk_count<=0, err<=0, go to GEN.
//   GEN:    aes_start=1 only in the first GEN cycle. aes_done is honoured from the next cycle on.
//           A done in the start cycle is ignored.
//           On an honoured done: ks_q<=aes_out, go to KS_RDY.
//           Timeout counter reaches 2^TMO_W-1 -> err<=1, go to IDLE.
//   KS_RDY: pt_ready=1. On pt_valid&pt_ready: ct_data<=pt_data^ks_q, iv_q<=pt_data^ks_q, ct_valid<=1, go to OUT.
//   OUT:    ct_valid held, ct_data stable until ct_ready. On ct_valid&ct_ready: ct_valid<=0, blk_count++, go to GEN.
//  Latency: ct_valid rises the cycle after the pt handshake.
//   Steady-state throughput = 1 block per (AES latency + 3) cycles with ct_ready tied high.
//  cfg_load outside GEN (KS_RDY/OUT, or pulse concurrent with a handshake):
//   - reload wins; an in-flight ciphertext is dropped (ct_valid<=0); a concurrent pt handshake is discarded.
//   - Go to GEN with the new IV.
//  cfg_load during GEN: the AES op cannot be aborted.
//   - Latch pend_q and cfg_iv; on the honoured done (or timeout) discard aes_out.
//   - Apply the reload; re-enter GEN (fresh aes_start); err stays cleared.
//   - A second cfg_load while pending overwrites the latched IV.
//  blk_count wraps 2^CNT_W-1 -> 0 without side effect.
//  pt_ready, aes_start and ct_valid are never asserted in IDLE.
//  rst_n assertion mid-operation returns everything to reset values immediately; a late aes_done is ignored in IDLE.
// TESTING (bench drives the real AES-128 core, key 2b7e151628aed2a6abf7158809cf4f3c; SP800-38A CFB128 vectors)
//  1 Reset/idle: rst_n low then high, no cfg_load, pt_valid=1 -> pt_ready, aes_start, ct_valid stay 0 for 100 cycles.
//  2 Chain: cfg_iv=000102030405060708090a0b0c0d0e0f, P1=6bc1bee22e409f96e93d7e117393172a
//     -> ct=3b3fd92eb72dad20333449f8e83cfb4a; P2=ae2d8a571e03ac9c9eb76fac45af8e51
//     -> ct=c8a64537a0b3a93fcde3cdad9f1ce58b; blk_count=2.
//  3 Backpressure: ct_ready low 20 cycles in case 2 -> ct_data stable, no aes_start, pt_ready=0; C2 still correct.
//  4 Reload in GEN: cfg_load (same IV) 2 cycles after aes_start -> stale result discarded, second aes_start issued.
//     P1 -> 3b3fd92e...; blk_count=1.
//  5 Timeout: stub core never raises aes_done -> err=1 after 255 GEN cycles, state IDLE; next cfg_load clears err.
//  6 Wrap/reset: CNT_W=2 stub run of 5 blocks -> blk_count 1,2,3,0,1; rst_n pulsed in OUT -> ct_valid=0 at once.

Source files
------------

// File: rtl/cfb_enc_ctrl.sv
// CFB-128 encryption sequencer: runs AES(iv) on an external multi-cycle core,
// XORs the keystream into plaintext and chains the ciphertext back as the next IV.
module cfb_enc_ctrl #(
    parameter int DW    = 128,
    parameter int CNT_W = 17,
    parameter int TMO_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_load,
    input  logic [DW-1:0]    cfg_iv,
    input  logic [DW-1:0]    pt_data,
    input  logic             pt_valid,
    output logic             pt_ready,
    output logic [DW-1:0]    ct_data,
    output logic             ct_valid,
    input  logic             ct_ready,
    output logic             aes_start,
    output logic [DW-1:0]    aes_in,
    input  logic             aes_done,
    input  logic [DW-1:0]    aes_out,
    output logic [CNT_W-1:0] blk_count,
    output logic             busy,
    output logic             err
);
    typedef enum logic [1:0] {S_IDLE, S_GEN, S_KS_RDY, S_OUT} state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
    localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [DW-1:0]    r_iv, r_ks, r_ct, r_pend_iv;
    logic             r_pend, r_ct_valid, r_start, r_pt_ready, r_err;
    logic [CNT_W-1:0] r_cnt;
    logic [TMO_W-1:0] r_tmo;

    logic          w_done, w_tmo, w_gen_end, w_reload, w_latch;
    logic [DW-1:0] w_reload_iv, w_ct;

    // A done coincident with the start pulse belongs to no request of ours.
    assign w_done      = aes_done && !r_start;
    assign w_tmo       = (r_tmo == TMO_LAST) && !w_done;
    assign w_gen_end   = (r_state == S_GEN) && (w_done || w_tmo);
    // The AES op cannot be aborted, so a reload in GEN waits for its end.
    assign w_reload    = (cfg_load && r_state != S_GEN) || (w_gen_end && (cfg_load || r_pend));
    assign w_latch     = cfg_load && (r_state == S_GEN) && !w_gen_end;
    assign w_reload_iv = cfg_load ? cfg_iv : r_pend_iv;
    assign w_ct        = pt_data ^ r_ks;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_iv       <= '0;
            r_ks       <= '0;
            r_ct       <= '0;
            r_pend_iv  <= '0;
            r_pend     <= 1'b0;
            r_ct_valid <= 1'b0;
            r_start    <= 1'b0;
            r_pt_ready <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_tmo      <= '0;
        end else begin
            r_start <= 1'b0;
            if (w_reload) begin
                r_iv       <= w_reload_iv;
                r_cnt      <= '0;
                r_err      <= 1'b0;
                r_pend     <= 1'b0;
                r_ct_valid <= 1'b0;
                r_pt_ready <= 1'b0;
                r_tmo      <= '0;
                r_start    <= 1'b1;
                r_state    <= S_GEN;
            end else begin
                if (w_latch) begin
                    r_pend    <= 1'b1;
                    r_pend_iv <= cfg_iv;
                end
                case (r_state)
                    S_GEN: begin
                        if (w_done) begin
                            r_ks       <= aes_out;
                            r_pt_ready <= 1'b1;
                            r_state    <= S_KS_RDY;
                        end else if (w_tmo) begin
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_tmo <= r_tmo + TMO_ONE;
                        end
                    end
                    S_KS_RDY: begin
                        if (pt_valid && r_pt_ready) begin
                            r_ct       <= w_ct;
                            r_iv       <= w_ct;
                            r_ct_valid <= 1'b1;
                            r_pt_ready <= 1'b0;
                            r_state    <= S_OUT;
                        end
                    end
                    S_OUT: begin
                        if (ct_ready) begin
                            r_ct_valid <= 1'b0;
                            r_cnt      <= r_cnt + CNT_ONE;
                            r_tmo      <= '0;
                            r_start    <= 1'b1;
                            r_state    <= S_GEN;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign pt_ready  = r_pt_ready;
    assign ct_data   = r_ct;
    assign ct_valid  = r_ct_valid;
    assign aes_start = r_start;
    assign aes_in    = r_iv;
    assign blk_count = r_cnt;
    assign busy      = (r_state != S_IDLE);
    assign err       = r_err;
endmodule

// File: tb/tb_cfb_enc_ctrl.sv
// Directed bench for cfb_enc_ctrl; a table-driven AES stub returns the SP800-38A
// CFB128 keystream (P^C) for known IVs, and iv^MASK for anything else.
module tb_cfb_enc_ctrl;
    localparam int DW = 128, CNT_W = 2, TMO_W = 8, LAT = 4;

    localparam logic [127:0] IV0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1   = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C1   = 128'h3b3fd92eb72dad20333449f8e83cfb4a;
    localparam logic [127:0] P2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C2   = 128'hc8a64537a0b3a93fcde3cdad9f1ce58b;
    localparam logic [127:0] MASK = 128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c;

    logic             clk = 1'b0, rst_n = 1'b0;
    logic             cfg_load = 1'b0, pt_valid = 1'b0, ct_ready = 1'b0;
    logic [DW-1:0]    cfg_iv = '0, pt_data = '0;
    logic             pt_ready, ct_valid, aes_start, busy, err;
    logic [DW-1:0]    ct_data, aes_in;
    logic             aes_done = 1'b0;
    logic [DW-1:0]    aes_out = '0;
    logic [CNT_W-1:0] blk_count;

    int errs = 0, checks = 0;
    logic stub_hang = 1'b0;

    cfb_enc_ctrl #(.DW(DW), .CNT_W(CNT_W), .TMO_W(TMO_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_iv(cfg_iv),
        .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready),
        .ct_data(ct_data), .ct_valid(ct_valid), .ct_ready(ct_ready),
        .aes_start(aes_start), .aes_in(aes_in), .aes_done(aes_done), .aes_out(aes_out),
        .blk_count(blk_count), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] ks_of(input logic [127:0] iv);
        if (iv == IV0) return P1 ^ C1;
        if (iv == C1)  return P2 ^ C2;
        return iv ^ MASK;
    endfunction

    // AES core stub: fixed latency from the start pulse to a one-cycle done.
    logic [7:0]   s_cnt = '0;
    logic         s_busy = 1'b0;
    logic [127:0] s_in = '0;
    always @(posedge clk) begin
        aes_done <= 1'b0;
        if (aes_start) begin
            s_busy <= 1'b1;
            s_cnt  <= 8'(LAT);
            s_in   <= aes_in;
        end else if (s_busy) begin
            if (s_cnt == 8'd1) begin
                s_busy <= 1'b0;
                if (!stub_hang) begin
                    aes_done <= 1'b1;
                    aes_out  <= ks_of(s_in);
                end
            end else begin
                s_cnt <= s_cnt - 8'd1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        cfg_load = 0; pt_valid = 0; ct_ready = 0; stub_hang = 0;
        rst_n = 0;
        step(); step();
        rst_n = 1;
        step();
    endtask

    task automatic load(input logic [127:0] iv);
        cfg_iv = iv; cfg_load = 1;
        step();
        cfg_load = 0;
    endtask

    task automatic wait_ready(output int starts);
        int n = 0;
        starts = 0;
        while (!pt_ready && n < 200) begin
            if (aes_start) starts++;
            step();
            n++;
        end
        checks++;
        if (pt_ready !== 1'b1) begin
            errs++;
            $display("FAIL wait_ready: pt_ready=%b required 1 within 200 cycles", pt_ready);
        end
    endtask

    // One block: handshake plaintext, optionally stall the sink, then accept.
    task automatic do_block(input logic [127:0] pt, input logic [127:0] exp_ct,
                            input logic [CNT_W-1:0] exp_cnt, input int hold, input string nm);
        int s;
        logic bad;
        wait_ready(s);
        pt_data = pt; pt_valid = 1;
        step();
        pt_valid = 0;
        checks++;
        if (ct_valid !== 1'b1 || ct_data !== exp_ct) begin
            errs++;
            $display("FAIL %s ct: valid=%b data=%h required valid=1 data=%h", nm, ct_valid, ct_data, exp_ct);
        end
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            step();
            if (ct_valid !== 1'b1 || ct_data !== exp_ct || aes_start !== 1'b0 || pt_ready !== 1'b0) bad = 1;
        end
        if (hold > 0) begin
            checks++;
            if (bad) begin
                errs++;
                $display("FAIL %s stall: last ct_valid=%b data=%h start=%b pt_ready=%b required 1/%h/0/0",
                         nm, ct_valid, ct_data, aes_start, pt_ready, exp_ct);
            end
        end
        ct_ready = 1;
        step();
        ct_ready = 0;
        checks++;
        if (blk_count !== exp_cnt || ct_valid !== 1'b0) begin
            errs++;
            $display("FAIL %s count: blk_count=%0d ct_valid=%b required %0d/0", nm, blk_count, ct_valid, exp_cnt);
        end
    endtask

    task automatic test_reset();
        logic bad = 0;
        rst_n = 0;
        #1;
        checks++;
        if (pt_ready !== 0 || ct_valid !== 0 || aes_start !== 0 || err !== 0 || busy !== 0 ||
            blk_count !== 0 || ct_data !== '0 || aes_in !== '0) begin
            errs++;
            $display("FAIL reset: rdy=%b vld=%b st=%b err=%b busy=%b cnt=%0d required all 0",
                     pt_ready, ct_valid, aes_start, err, busy, blk_count);
        end
        step(); rst_n = 1; pt_valid = 1; pt_data = P1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (pt_ready !== 0 || aes_start !== 0 || ct_valid !== 0 || busy !== 0) bad = 1;
        end
        pt_valid = 0;
        checks++;
        if (bad) begin
            errs++;
            $display("FAIL idle: rdy=%b st=%b vld=%b busy=%b required 0 for 100 cycles", pt_ready, aes_start, ct_valid, busy);
        end
    endtask

    task automatic test_chain(input int hold, input string nm);
        apply_reset();
        load(IV0);
        checks++;
        if (aes_start !== 1'b1 || aes_in !== IV0 || busy !== 1'b1) begin
            errs++;
            $display("FAIL %s start: aes_start=%b aes_in=%h required 1/%h", nm, aes_start, aes_in, IV0);
        end
        do_block(P1, C1, 2'd1, 0, nm);
        do_block(P2, C2, 2'd2, hold, nm);
    endtask

    task automatic test_reload_in_gen();
        int s;
        apply_reset();
        load(IV0);
        step(); step();
        cfg_iv = IV0; cfg_load = 1;
        step();
        cfg_load = 0;
        wait_ready(s);
        checks++;
        if (s !== 1) begin
            errs++;
            $display("FAIL reload_gen starts: %0d extra aes_start pulses, required 1", s);
        end
        do_block(P1, C1, 2'd1, 0, "reload_gen");
    endtask

    task automatic test_timeout();
        apply_reset();
        stub_hang = 1;
        load(128'h1234);
        repeat (254) step();
        checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            errs++;
            $display("FAIL timeout early: busy=%b err=%b required 1/0 after 254 cycles", busy, err);
        end
        step();
        checks++;
        if (busy !== 1'b0 || err !== 1'b1) begin
            errs++;
            $display("FAIL timeout fire: busy=%b err=%b required 0/1 after 255 cycles", busy, err);
        end
        stub_hang = 0;
        load(128'h1234);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1 || aes_start !== 1'b1) begin
            errs++;
            $display("FAIL timeout clear: err=%b busy=%b start=%b required 0/1/1", err, busy, aes_start);
        end
    endtask

    task automatic test_wrap_and_reset();
        logic [127:0] iv, pt, ct;
        logic [CNT_W-1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        int s;
        apply_reset();
        iv = 128'hdeadbeef_00000000_cafef00d_11111111;
        load(iv);
        for (int k = 0; k < 5; k++) begin
            pt = {4{32'h01010101 * (k + 3)}};
            ct = pt ^ (iv ^ MASK);
            do_block(pt, ct, exp_cnt[k], 0, $sformatf("wrap%0d", k));
            iv = ct;
        end
        wait_ready(s);
        pt_data = 128'h77; pt_valid = 1;
        step();
        pt_valid = 0;
        rst_n = 0;
        #1;
        checks++;
        if (ct_valid !== 1'b0 || busy !== 1'b0 || blk_count !== 0 || ct_data !== '0) begin
            errs++;
            $display("FAIL reset_in_out: ct_valid=%b busy=%b cnt=%0d required 0/0/0", ct_valid, busy, blk_count);
        end
        step(); rst_n = 1;
        repeat (10) step();
        checks++;
        if (busy !== 1'b0 || pt_ready !== 1'b0 || aes_start !== 1'b0) begin
            errs++;
            $display("FAIL late_done: busy=%b pt_ready=%b start=%b required 0/0/0", busy, pt_ready, aes_start);
        end
    endtask

    initial begin
        test_reset();
        test_chain(0, "chain");
        test_chain(20, "backpressure");
        test_reload_in_gen();
        test_timeout();
        test_wrap_and_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
